// File: rtl/seq_det_pkg.sv
// Shared types and limits for the serial pattern detector.
// Holds the Moore state encoding and the legal pattern-width range.
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// When clear and increment arrive together, clear wins.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with a loadable pattern and a saturating match count.
// op is a pure decode of the state register, one cycle after the completing sample.
//
// state | meaning
// FILL  | fewer than PAT_W valid bits collected since reset/load/non-overlap match
// RUN   | history window full, last accepted sample did not match
// HIT   | last accepted sample completed a match (op high)
module seq_detect_moore
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_W    = 4,
    parameter logic [PAT_W-1:0]     PAT_INIT = 4'b1001,
    parameter bit                   OVERLAP  = 1'b1,
    parameter int unsigned          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ip,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             op,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_detect_moore: PAT_W out of legal range");
    end

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        pat_d      = pat_q;
        fill_d     = fill_q;
        match      = 1'b0;
        hist_shift = {hist_q[PAT_W-2:0], ip};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

        if (pat_load) begin
            // a load discards the coincident sample entirely
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (en) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if ((fill_inc == FILL_FULL) && (hist_shift == pat_q)) begin
                match   = 1'b1;
                state_d = HIT;
                if (!OVERLAP) begin
                    fill_d = '0;
                end
            end else if (fill_inc == FILL_FULL) begin
                state_d = RUN;
            end else begin
                state_d = FILL;
            end
        end else if (state_q == HIT) begin
            state_d = (fill_q == FILL_FULL) ? RUN : FILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            hist_q  <= '0;
            pat_q   <= PAT_INIT;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
        end
    end

    assign op = (state_q == HIT);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (match),
        .clr   (clr_cnt),
        .count (match_cnt)
    );

endmodule

// File: doc/seq_detect_moore.md
SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits; legal range is 2..16.
REQ-002 The block SHALL have parameter PAT_INIT, default 4'b1001, giving the pattern loaded at reset.
REQ-003 The block SHALL have parameter OVERLAP, default 1, selecting overlapping detection when 1 and non-overlapping detection when 0.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: when high, ip is a valid serial sample this cycle.
REQ-008 The block SHALL have port ip, input, 1 bit: the serial data bit.
REQ-009 The block SHALL have port pat_load, input, 1 bit: when high, loads pat_in as the new pattern.
REQ-010 The block SHALL have port pat_in, input, PAT_W bits: the new pattern; its MSB is compared with the oldest bit.
REQ-011 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of match_cnt.
REQ-012 The block SHALL have port op, output, 1 bit: the Moore detect flag, high only in state HIT.
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits: the saturating count of detections.

Function
REQ-014 The block SHALL keep a PAT_W-bit history register, a fill counter (0..PAT_W), a pattern register and a state in {FILL, RUN, HIT}.
REQ-015 On an edge with en=1 and pat_load=0, history SHALL shift to {history[PAT_W-2:0], ip}, and fill SHALL increment, saturating at PAT_W.
REQ-016 A match SHALL occur on an accepted sample when the post-shift fill equals PAT_W and the post-shift history equals the pattern register.
REQ-017 Transitions on accepted samples: a match SHALL go to HIT; otherwise, fill=PAT_W SHALL go to RUN; otherwise the block SHALL go to FILL.
REQ-018 When en=0, HIT SHALL go to RUN if fill=PAT_W and to FILL otherwise; FILL and RUN SHALL hold; history and fill SHALL not change.
REQ-019 op SHALL be decoded from state only (no combinational path from ip, en or pat_in); latency is exactly one cycle, high in the cycle after the completing sample's edge.
REQ-020 With OVERLAP=1, fill SHALL stay at PAT_W after a match, so consecutive matches can yield op high on back-to-back cycles.
REQ-021 With OVERLAP=0, fill SHALL be set to 0 on a match, so no bit of a matched window contributes to a later match.
REQ-022 pat_load=1 SHALL load pat_in, clear history and fill, and enter FILL.
REQ-023 pat_load SHALL take priority over en in the same cycle; the sample is discarded and no match is evaluated.
REQ-024 match_cnt SHALL increment by 1 on each transition into HIT and SHALL saturate at 2^CNT_W-1.
REQ-025 When clr_cnt coincides with a match, clear SHALL win: match_cnt=0 and op still asserts.
REQ-026 A pattern load SHALL not affect match_cnt.

Reset
REQ-027 Reset assertion SHALL immediately, without waiting for clk, force: state=FILL, op=0, match_cnt=0, history=0, fill=0, pattern=PAT_INIT.
REQ-028 Reset asserted mid-sequence SHALL discard any partial match; detection restarts from fill=0 on the first accepted sample after release.
REQ-029 Reset deassertion SHALL take effect at the first clk edge after release; no sample is accepted while reset is low.

Structure
REQ-030 A shared package seq_det_pkg SHALL hold the state enum type (FILL, RUN, HIT) and the PAT_W legal-range limits.
REQ-031 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; inputs inc and clr; output count).
REQ-032 The block SHALL contain no latches, and all outputs SHALL be registered or pure state decodes.

Verification
REQ-033 Defaults, en=1, ip stream 1,0,0,1,0,0,1 -> op high after the 4th and 7th samples; match_cnt=2.
REQ-034 OVERLAP=0, same stream -> op high only after the 4th sample; match_cnt=1.
REQ-035 Stream 1,0,0 with en dropped for 3 cycles, then 1 -> op high once after the final sample; en gaps do not break a match.
REQ-036 pat_load with pat_in=4'b1111 coinciding with en=1, ip=1, followed by four 1s -> the loading sample is ignored; op high after the 4th following 1; not before.
REQ-037 CNT_W=2 with 5 matches -> match_cnt saturates at 3; clr_cnt coinciding with the 6th match -> match_cnt=0 and op=1 that cycle.
REQ-038 Reset asserted asynchronously after samples 1,0,0, then released and 1 applied -> no op; outputs are 0 immediately on assertion, without a clock edge.
